// File: rtl/demux1_to_21_loader.sv
// demux1_to_21_loader: serial-to-parallel distributor. N-bit words accepted one
// per valid/ready handshake are written in order into 21 holding registers
// (slot 0..20) that are presented in parallel on x_o. done_o pulses for one
// cycle after slot 20 is written.
// Optional build macro LOADER_CLEAR_ON_START_EN: when defined, every accepted
// start_i also clears all 21 slots to zero on the same edge.
module demux1_to_21_loader #(
  parameter int N = 18
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [N-1:0]    data_i,
  input  logic            valid_i,
  output logic            ready_o,
  output logic [21*N-1:0] x_o,
  output logic [5:0]      sel_o,
  output logic            busy_o,
  output logic            done_o
);

  localparam int unsigned SLOTS = 21;
  localparam logic [5:0] LAST_SEL = 6'd20;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE
  } state_t;

  state_t       state;
  logic [N-1:0] slot [SLOTS];

  // Control FSM, write index, registered status outputs and the slot bank.
  // start_i behaves identically in every state (enter/restart LOAD at slot 0),
  // so it is handled once ahead of the per-state decode; it also takes
  // priority over a same-cycle transfer.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= IDLE;
      sel_o   <= '0;
      ready_o <= 1'b0;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
      for (int unsigned k = 0; k < SLOTS; k++) begin
        slot[k] <= '0;
      end
    end else begin
      done_o <= 1'b0;
      if (start_i) begin
        state   <= LOAD;
        sel_o   <= '0;
        ready_o <= 1'b1;
        busy_o  <= 1'b1;
`ifdef LOADER_CLEAR_ON_START_EN
        for (int unsigned k = 0; k < SLOTS; k++) begin
          slot[k] <= '0;
        end
`endif
      end else begin
        case (state)
          IDLE: begin
            ready_o <= 1'b0;
            busy_o  <= 1'b0;
          end
          LOAD: begin
            if (valid_i) begin
              for (int unsigned k = 0; k < SLOTS; k++) begin
                if (sel_o == 6'(k)) begin
                  slot[k] <= data_i;
                end
              end
              if (sel_o == LAST_SEL) begin
                state   <= DONE;
                sel_o   <= '0;
                ready_o <= 1'b0;
                busy_o  <= 1'b0;
                done_o  <= 1'b1;
              end else begin
                sel_o <= sel_o + 6'd1;
              end
            end
          end
          DONE: begin
            state   <= IDLE;
            ready_o <= 1'b0;
            busy_o  <= 1'b0;
          end
          default: begin
            state   <= IDLE;
            sel_o   <= '0;
            ready_o <= 1'b0;
            busy_o  <= 1'b0;
          end
        endcase
      end
    end
  end

  // Flatten the slot bank onto x_o, slot k at bits [k*N +: N].
  always_comb begin
    x_o = '0;
    for (int unsigned k = 0; k < SLOTS; k++) begin
      x_o[k*N +: N] = slot[k];
    end
  end

endmodule
